bus_master_arbiter: RTL and testbench

//  Bus master for the dValid/dAck/data 8-bit transfer protocol. Shares the bus among
//  N_REQ local requesters using round-robin arbitration. Drives dValid and data per

---
 rtl/bus_master_if.sv | 9 +
 rtl/bus_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bus_master_if.sv
// Point-to-point dValid/dAck/data bus between the arbiter (master) and the bus target (slave).
interface bus_master_if;
  logic       dValid;
  logic [7:0] data;
  logic       dAck;

  modport master (output dValid, output data, input dAck);
  modport slave  (input dValid, input data, output dAck);
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin bus master for the dValid/dAck/data protocol, with dAck timeout and early-ack flagging.
// Optional feature: define BUS_RETRY_EN to re-issue a timed-out transfer once before reporting err.
module bus_master_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ACK_MIN = 2,
  parameter int ACK_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     proto_err,
  bus_master_if.master             bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACK_MAX + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t           state, state_n;
  logic             dvalid_q, dvalid_n;
  logic [7:0]       data_q, data_n;
  logic [IDX_W-1:0] grant_q, grant_n;
  logic [IDX_W-1:0] rr_q, rr_n;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ack_q, ack_n;     // accepted dAck seen; end transfer next edge
  logic             to_q, to_n;       // ACK_MAX reached without dAck
  logic [N_REQ-1:0] done_n, err_n;
  logic             perr_n;
`ifdef BUS_RETRY_EN
  logic             retry_q, retry_n;
`endif

  assign bus.dValid = dvalid_q;
  assign bus.data   = data_q;
  assign grant_id   = grant_q;
  assign busy       = (state != IDLE);

  // Round-robin search starting just after the last served requester; the lowest
  // distance from rr_q wins, so iterate from farthest to nearest.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n  = state;
    dvalid_n = dvalid_q;
    data_n   = data_q;
    grant_n  = grant_q;
    rr_n     = rr_q;
    cnt_n    = cnt_q;
    ack_n    = ack_q;
    to_n     = to_q;
    done_n   = '0;
    err_n    = '0;
    perr_n   = 1'b0;
`ifdef BUS_RETRY_EN
    retry_n  = retry_q;
`endif

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n  = DRIVE;
          dvalid_n = 1'b1;
          data_n   = req_data[8*int'(pick) +: 8];
          grant_n  = pick;
          cnt_n    = '0;
          ack_n    = 1'b0;
          to_n     = 1'b0;
`ifdef BUS_RETRY_EN
          retry_n  = 1'b0;
`endif
        end
      end

      DRIVE: begin
        if (ack_q) begin
          state_n          = GAP;
          dvalid_n         = 1'b0;
          done_n[grant_q]  = 1'b1;
          rr_n             = grant_q;
        end else if (to_q) begin
          state_n  = GAP;
          dvalid_n = 1'b0;
          rr_n     = grant_q;
`ifdef BUS_RETRY_EN
          if (retry_q) err_n[grant_q] = 1'b1;
          else         retry_n        = 1'b1;
`else
          err_n[grant_q] = 1'b1;
`endif
        end else begin
          if (bus.dAck && (cnt_q < CNT_W'(ACK_MIN))) perr_n = 1'b1;
          else if (bus.dAck)                         ack_n  = 1'b1;
          else if (cnt_q == CNT_W'(ACK_MAX))         to_n   = 1'b1;
          if (cnt_q != CNT_W'(ACK_MAX)) cnt_n = cnt_q + 1'b1;
        end
      end

      GAP: begin
        state_n = IDLE;
`ifdef BUS_RETRY_EN
        // A suppressed timeout leaves both done and err low in GAP: re-issue the same beat.
        if (retry_q && (done == '0) && (err == '0)) begin
          state_n  = DRIVE;
          dvalid_n = 1'b1;
          cnt_n    = '0;
          ack_n    = 1'b0;
          to_n     = 1'b0;
        end
`endif
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dvalid_q  <= 1'b0;
      data_q    <= '0;
      grant_q   <= '0;
      rr_q      <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
      done      <= '0;
      err       <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      dvalid_q  <= dvalid_n;
      data_q    <= data_n;
      grant_q   <= grant_n;
      rr_q      <= rr_n;
      cnt_q     <= cnt_n;
      ack_q     <= ack_n;
      to_q      <= to_n;
      done      <= done_n;
      err       <= err_n;
      proto_err <= perr_n;
    end
  end

`ifdef BUS_RETRY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retry_q <= 1'b0;
    else          retry_q <= retry_n;
  end
`endif
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter: single beat, round-robin order,
// early dAck flagging, timeout, and asynchronous reset mid-transfer.
module tb_bus_master_arbiter;
  localparam int N_REQ = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [8*N_REQ-1:0]   req_data = '0;
  logic [N_REQ-1:0]     done, err;
  logic                 busy, proto_err;
  logic [1:0]           grant_id;
  int                   n_total = 0;
  int                   n_bad = 0;

  bus_master_if bus ();

  bus_master_arbiter #(.N_REQ(N_REQ), .ACK_MIN(2), .ACK_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .grant_id  (grant_id),
    .proto_err (proto_err),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for dValid, drives dAck per cycle from ack_mask (bit = wait_cnt), returns in GAP cycle.
  task automatic xfer(input string tag, input logic [15:0] ack_mask, input int exp_gid,
                      input logic [7:0] exp_data, input int exp_high,
                      input logic [N_REQ-1:0] exp_done, input logic [N_REQ-1:0] exp_err,
                      input int exp_perr);
    int n = 0;
    int high = 0;
    int perr = 0;
    logic [N_REQ-1:0] early = '0;
    while (!bus.dValid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rise"}, int'(bus.dValid), 1);
    check({tag, "_gid"}, int'(grant_id), exp_gid);
    req_data = $urandom;  // must not leak into the latched beat
    while (bus.dValid && high < 16) begin
      check({tag, "_data"}, int'(bus.data), int'(exp_data));
      bus.dAck = ack_mask[high];
      tick();
      high++;
      if (proto_err) perr++;
      if (bus.dValid) early |= (done | err);
    end
    bus.dAck = 1'b0;
    check({tag, "_high"}, high, exp_high);
    check({tag, "_early"}, int'(early), 0);
    check({tag, "_done"}, int'(done), int'(exp_done));
    check({tag, "_err"}, int'(err), int'(exp_err));
    check({tag, "_perr"}, perr, exp_perr);
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_dvalid", int'(bus.dValid), 0);
    check("rst_data", int'(bus.data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gid", int'(grant_id), 0);
    check("rst_flags", int'({done, err, proto_err}), 0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.dAck = 1'b0;
    do_reset();
    tick();

    // 1: single transfer from requester 0, ack at wait_cnt=2
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    tick();
    check("t1_latency", int'(bus.dValid), 1);
    xfer("t1", 16'h0004, 0, 8'hA5, 4, 4'b0001, 4'b0000, 0);
    req = 4'b0000;
    check("t1_hold_gap", int'(bus.data), 8'hA5);
    tick();
    check("t1_hold_idle", int'(bus.data), 8'hA5);
    check("t1_done_once", int'(done), 0);
    check("t1_idle_busy", int'(busy), 0);

    // 2: all four requesting, eight transfers in round-robin order from a fresh reset
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      req_data = 32'h43424140;
      xfer($sformatf("t2_%0d", i), 16'h0004, i % 4, 8'(8'h40 + i % 4), 4,
           4'(1 << (i % 4)), 4'b0000, 0);
    end
    req = 4'b0000;
    tick();

    // 3: early dAck at wait_cnt=0 is flagged and ignored; accepted at wait_cnt=3
    req = 4'b0010;
    req_data[15:8] = 8'h3C;
    xfer("t3", 16'h0009, 1, 8'h3C, 5, 4'b0010, 4'b0000, 1);
    req = 4'b0000;
    tick();

    // 4: no dAck at all -> timeout after 6 high cycles
    req = 4'b1000;
    req_data[31:24] = 8'h77;
`ifdef BUS_RETRY_EN
    xfer("t4a", 16'h0000, 3, 8'h77, 6, 4'b0000, 4'b0000, 0);
    xfer("t4b", 16'h0000, 3, 8'h77, 6, 4'b0000, 4'b1000, 0);
`else
    xfer("t4", 16'h0000, 3, 8'h77, 6, 4'b0000, 4'b1000, 0);
`endif
    req = 4'b0000;
    bus.dAck = 1'b1;  // dAck outside DRIVE must be ignored
    tick();
    check("t4_idle_perr", int'(proto_err), 0);
    check("t4_idle_busy", int'(busy), 0);
    tick();
    check("t4_idle_perr2", int'(proto_err), 0);
    check("t4_idle_dvalid", int'(bus.dValid), 0);
    bus.dAck = 1'b0;

    // 5: asynchronous reset during DRIVE, then requester 2 wins first
    req = 4'b0001;
    req_data[7:0] = 8'h5A;
    tick();
    check("t5_drive", int'(bus.dValid), 1);
    tick();
    req = 4'b0100;
    req_data[23:16] = 8'h99;
    reset_n = 1'b0;
    #1;
    check("t5_async_dvalid", int'(bus.dValid), 0);
    check("t5_async_data", int'(bus.data), 0);
    check("t5_async_busy", int'(busy), 0);
    tick();
    check("t5_no_flags", int'({done, err}), 0);
    reset_n = 1'b1;
    xfer("t5", 16'h0004, 2, 8'h99, 4, 4'b0100, 4'b0000, 0);
    req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
